// File: rtl/cnn_pkg.sv
// Shared types and layer-1 geometry for the CNN front end.
// The window generator and its delay lines import these constants.
package cnn_pkg;

    localparam int LAYER1_DATA_W = 16;
    localparam int LAYER1_IMG_W  = 32;
    localparam int LAYER1_IMG_H  = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } win_state_t;

    typedef logic [LAYER1_DATA_W-1:0] pix_t;

endpackage

// File: rtl/line_delay_en.sv
// Enable-gated shift register: output is the input delayed by DEPTH enabled cycles.
// Used as a row-delay line between tap rows of the window generator.
module line_delay_en
    import cnn_pkg::*;
#(
    parameter int DATA_W = LAYER1_DATA_W,
    parameter int DEPTH  = LAYER1_IMG_W - 3
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_sr [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sr[i] <= '0;
            end
        end else if (i_en) begin
            r_sr[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_data = r_sr[DEPTH-1];

endmodule

// File: rtl/layer1_window_gen.sv
// Layer-1 3x3 sliding-window generator: raster pixels in, one 3x3 window per
// accepted pixel (row>=2, col>=2) out, with valid/ready on both sides.
//
// state    | meaning
// S_IDLE   | waiting for the first pixel of a frame
// S_FILL   | rows 0..1 and the start of row 2 are filling the taps
// S_STREAM | every accepted pixel at col>=2 yields a window
// S_DONE   | last pixel taken; waiting for the final window handshake
module layer1_window_gen
    import cnn_pkg::*;
#(
    parameter  int DATA_W = LAYER1_DATA_W,
    parameter  int IMG_W  = LAYER1_IMG_W,
    parameter  int IMG_H  = LAYER1_IMG_H,
    localparam int ROW_W  = $clog2(IMG_H),
    localparam int COL_W  = $clog2(IMG_W)
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   pixel_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [9*DATA_W-1:0] out_window,
    output logic [ROW_W-1:0]    out_row,
    output logic [COL_W-1:0]    out_col,
    output logic                frame_done
);

    win_state_t          r_state;
    logic [DATA_W-1:0]   r_tap     [3][3];
    logic [DATA_W-1:0]   w_tap_nxt [3][3];
    logic [DATA_W-1:0]   w_dl0_out;
    logic [DATA_W-1:0]   w_dl1_out;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic                r_out_valid;
    logic [9*DATA_W-1:0] r_out_window;
    logic [ROW_W-1:0]    r_out_row;
    logic [COL_W-1:0]    r_out_col;
    logic                r_frame_done;
    logic [9*DATA_W-1:0] w_window;
    logic                w_acc;
    logic                w_hs;
    logic                w_col_last;
    logic                w_row_last;
    logic                w_win_ok;
    logic                w_load;
    logic                w_fill_end;
    logic                w_frame_end;

    assign in_ready    = (r_state != S_DONE) && (!r_out_valid || out_ready);
    assign w_acc       = in_valid && in_ready;
    assign w_hs        = r_out_valid && out_ready;
    assign w_col_last  = (r_col == COL_W'(IMG_W - 1));
    assign w_row_last  = (r_row == ROW_W'(IMG_H - 1));
    assign w_win_ok    = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
    // A frame_start pixel is always (0,0), so it never produces a window.
    assign w_load      = w_acc && !frame_start && w_win_ok;
    assign w_fill_end  = (r_row == ROW_W'(2)) && (r_col == COL_W'(2));
    assign w_frame_end = w_row_last && w_col_last;

    // Column 2 of each tap row is the newest pixel; column 0 leaves into the delay lines.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_tap_nxt[r][0] = r_tap[r][1];
            w_tap_nxt[r][1] = r_tap[r][2];
            w_tap_nxt[r][2] = r_tap[r][2];
        end
        w_tap_nxt[2][2] = pixel_in;
        w_tap_nxt[1][2] = w_dl0_out;
        w_tap_nxt[0][2] = w_dl1_out;
    end

    always_comb begin
        w_window = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_window[(r*3+c)*DATA_W +: DATA_W] = w_tap_nxt[r][c];
            end
        end
    end

    line_delay_en #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W - 3)
    ) u_dl0 (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (w_acc),
        .i_data (r_tap[2][0]),
        .o_data (w_dl0_out)
    );

    line_delay_en #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W - 3)
    ) u_dl1 (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (w_acc),
        .i_data (r_tap[1][0]),
        .o_data (w_dl1_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_tap[r][c] <= '0;
                end
            end
        end else if (w_acc) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_tap[r][c] <= w_tap_nxt[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (frame_start) begin
            r_col <= w_acc ? COL_W'(1) : '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_window <= '0;
            r_out_row    <= '0;
            r_out_col    <= '0;
        end else if (frame_start) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid  <= 1'b1;
            r_out_window <= w_window;
            r_out_row    <= r_row;
            r_out_col    <= r_col;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (frame_start) begin
                r_state <= w_acc ? S_FILL : S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE:   if (w_acc) r_state <= S_FILL;
                    S_FILL:   if (w_acc && w_fill_end) r_state <= S_STREAM;
                    S_STREAM: if (w_acc && w_frame_end) r_state <= S_DONE;
                    S_DONE: begin
                        if (w_hs) begin
                            r_state      <= S_IDLE;
                            r_frame_done <= 1'b1;
                        end
                    end
                    default:  r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_window = r_out_window;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_layer1_window_gen.sv
// Directed bench for layer1_window_gen: scenario table of whole-frame runs
// checked against a pixel-image model, plus hand-written reset/stall/restart checks.
module tb_layer1_window_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         frame_start;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  pixel_in;
    logic         out_valid;
    logic         out_ready;
    logic [143:0] out_window;
    logic [4:0]   out_row;
    logic [4:0]   out_col;
    logic         frame_done;

    layer1_window_gen dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pixel_in    (pixel_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_window  (out_window),
        .out_row     (out_row),
        .out_col     (out_col),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int           r;
        int           c;
        logic [143:0] win;
    } win_t;

    typedef struct {
        bit toggle;
        bit stall;
        int fs_at;
        int rst_at;
        int frames;
        int exp_win;
        int exp_fd;
    } scen_t;

    win_t         q[$];
    logic [15:0]  img [32][32];
    int           m_r = 0;
    int           m_c = 0;
    int           n_win;
    int           n_fd;
    bit           pend = 0;
    bit           last_acc;
    bit           track_fs = 0;
    int           acc_since_fs;
    bit           first_seen = 0;
    logic [143:0] first_win;

    function automatic logic [143:0] exp_win(input int r, input int c);
        logic [143:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(i*3+j)*16 +: 16] = img[r-2+i][c-2+j];
        return w;
    endfunction

    // One clock cycle: called at a negedge, drives inputs, samples 1 time unit later.
    task automatic cycle(input bit iv, input logic [15:0] px, input bit fs,
                         input bit ordy, input bit stall_chk);
        bit acc;
        bit hs;
        in_valid    = iv;
        pixel_in    = px;
        frame_start = fs;
        out_ready   = ordy;
        #1;
        acc = iv && in_ready;
        hs  = out_valid && ordy;
        if (stall_chk && q.size() > 0) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_window_hold", out_window, q[0].win);
        end
        if (pend) chk("latency_out_valid", out_valid, 1);
        if (q.size() == 0) chk("no_spurious_valid", out_valid, 0);
        if (hs && q.size() > 0) begin
            chk("win_row", out_row, q[0].r);
            chk("win_col", out_col, q[0].c);
            chk("win_taps", out_window, q[0].win);
            if (!first_seen) begin
                first_seen = 1;
                first_win  = out_window;
            end
            void'(q.pop_front());
            n_win++;
        end
        if (frame_done) n_fd++;
        pend = 0;
        if (fs) begin
            m_r = 0;
            m_c = 0;
            q.delete();
            track_fs     = 1;
            acc_since_fs = 0;
        end
        if (acc) begin
            img[m_r][m_c] = px;
            if (track_fs) acc_since_fs++;
            if (m_r >= 2 && m_c >= 2) begin
                q.push_back('{m_r, m_c, exp_win(m_r, m_c)});
                pend = 1;
                if (track_fs) begin
                    chk("fs_restart_accepts", acc_since_fs, 67);
                    track_fs = 0;
                end
            end
            if (m_c == 31) begin
                m_c = 0;
                m_r = (m_r == 31) ? 0 : m_r + 1;
            end else begin
                m_c++;
            end
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic run_frame(input scen_t s);
        int idx;
        int guard;
        int fcount;
        int stall_left;
        bit tog;
        bit stalled;
        bit fs_done;
        bit rst_done;
        bit iv;
        bit ordy;
        bit sc;
        bit fs;
        idx = 0; guard = 0; fcount = 0; stall_left = 0;
        tog = 1; stalled = 0; fs_done = 0; rst_done = 0;
        while (fcount < s.frames && guard < 30000) begin
            guard++;
            if (s.rst_at >= 0 && !rst_done && idx == s.rst_at) begin
                rst = 1'b1;
                #2;
                chk("midrst_out_valid", out_valid, 0);
                chk("midrst_out_window", out_window, 0);
                chk("midrst_out_row", out_row, 0);
                chk("midrst_out_col", out_col, 0);
                chk("midrst_frame_done", frame_done, 0);
                @(negedge clk);
                rst = 1'b0;
                q.delete();
                pend = 0; m_r = 0; m_c = 0; idx = 0; rst_done = 1;
            end
            iv  = s.toggle ? tog : 1'b1;
            tog = !tog;
            ordy = 1'b1;
            sc   = 1'b0;
            if (s.stall && !stalled && out_valid && q.size() > 0 && q[0].r == 10 && q[0].c == 10) begin
                stalled    = 1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                ordy = 1'b0;
                sc   = 1'b1;
                stall_left--;
            end
            fs = 1'b0;
            if (s.fs_at >= 0 && !fs_done && idx == s.fs_at) begin
                fs      = 1'b1;
                fs_done = 1;
                idx     = 0;
            end
            cycle(iv, 16'(idx), fs, ordy, sc);
            if (last_acc) begin
                idx++;
                if (idx == 1024) begin
                    idx = 0;
                    fcount++;
                end
            end
        end
        chk("frames_completed", fcount, s.frames);
        for (int k = 0; k < 8; k++) cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    endtask

    scen_t        scen [6];
    int           fv [9];
    logic [143:0] fw;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        scen[0] = '{0, 0,  -1,  -1, 1,  900, 1};
        scen[1] = '{0, 1,  -1,  -1, 1,  900, 1};
        scen[2] = '{1, 0,  -1,  -1, 1,  900, 1};
        scen[3] = '{0, 0, 167,  -1, 1,  995, 1};
        scen[4] = '{0, 0,  -1, 643, 1, 1440, 1};
        scen[5] = '{0, 0,  -1,  -1, 2, 1800, 2};
        fv = '{0, 1, 2, 32, 33, 34, 64, 65, 66};
        fw = '0;
        for (int k = 0; k < 9; k++) fw[k*16 +: 16] = 16'(fv[k]);

        rst = 1'b1; frame_start = 1'b0; in_valid = 1'b0; pixel_in = '0; out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_window", out_window, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            n_win = 0;
            n_fd  = 0;
            run_frame(scen[i]);
            chk($sformatf("windows_s%0d", i), n_win, scen[i].exp_win);
            chk($sformatf("frame_done_s%0d", i), n_fd, scen[i].exp_fd);
            if (i == 0) begin
                chk("first_window_seen", first_seen, 1);
                chk("first_window_taps", first_win, fw);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
